i2c_req_arbiter: RTL and testbench

Shares one i2c master (single-transaction write/read interface with busy/done/status) between NUM_REQ client requesters. Round-robin arbitration; the block latches the winning request, pulses the master's write_en or read_en, tracks busy until completion and returns read data and status to the winner. It sits between the register-access clients and the i2c master instance, in the same clock domain as the master.

---
 rtl/i2c_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 33 +++
 rtl/i2c_req_arbiter.sv | 170 +++++++++++++++++
 tb/tb_i2c_req_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared widths, FSM state encoding and a saturating counter helper for the
// i2c request arbiter.
package i2c_pkg;

  localparam int I2C_CHIP_W   = 7;
  localparam int I2C_REG_W    = 8;
  localparam int I2C_DATA_W   = 16;
  localparam int I2C_STATUS_W = 4;
  localparam int I2C_CNT_W    = 16;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE       = 3'd0;
  localparam state_t ST_ISSUE      = 3'd1;
  localparam state_t ST_WAIT_START = 3'd2;
  localparam state_t ST_WAIT_DONE  = 3'd3;
  localparam state_t ST_RESP       = 3'd4;

  function automatic logic [I2C_CNT_W-1:0] sat_inc(input logic [I2C_CNT_W-1:0] v);
    return (v == {I2C_CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request searching upward from
// the slot after the last grant, wrapping modulo N.
module rr_arbiter #(
  parameter int N    = 4,
  parameter int IDXW = $clog2(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [IDXW-1:0] last_i,
  output logic [N-1:0]    grant_o,
  output logic [IDXW-1:0] idx_o,
  output logic            any_o
);

  logic [IDXW-1:0] cand;
  logic            found;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = '0;
    for (int off = 1; off <= N; off++) begin
      cand = IDXW'((int'(last_i) + off) % N);
      if (!found && req_i[cand]) begin
        found          = 1'b1;
        idx_o          = cand;
        grant_o[cand]  = 1'b1;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Shares one single-transaction i2c master between NUM_REQ clients: round-robin
// grant, one enable pulse per transaction, start/completion timeouts, response return.
module i2c_req_arbiter
  import i2c_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int START_WAIT = 8,
  parameter int TIMEOUT    = 65535
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0]              req_rw,
  input  logic [NUM_REQ*I2C_CHIP_W-1:0]   req_chip_addr,
  input  logic [NUM_REQ*I2C_REG_W-1:0]    req_reg_addr,
  input  logic [NUM_REQ*I2C_DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [I2C_DATA_W-1:0]           rsp_rdata,
  output logic [I2C_STATUS_W-1:0]         rsp_status,
  output logic                            rsp_err,
  output logic [I2C_CHIP_W-1:0]           m_chip_addr,
  output logic [I2C_REG_W-1:0]            m_reg_addr,
  output logic [I2C_DATA_W-1:0]           m_data_in,
  output logic                            m_write_en,
  output logic                            m_read_en,
  input  logic [I2C_DATA_W-1:0]           m_data_out,
  input  logic                            m_busy,
  input  logic [I2C_STATUS_W-1:0]         m_status
);

  localparam int IDXW = $clog2(NUM_REQ);
  localparam logic [I2C_CNT_W-1:0] START_LIM = I2C_CNT_W'(START_WAIT);
  localparam logic [I2C_CNT_W-1:0] DONE_LIM  = I2C_CNT_W'(TIMEOUT);

  state_t                  state_q, state_d;
  logic [I2C_CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDXW-1:0]         rr_ptr_q;
  logic [NUM_REQ-1:0]      grant_oh_q;
  logic                    rw_q;
  logic [I2C_CHIP_W-1:0]   chip_q;
  logic [I2C_REG_W-1:0]    reg_q;
  logic [I2C_DATA_W-1:0]   wdata_q;
  logic [I2C_DATA_W-1:0]   rdata_q;
  logic [I2C_STATUS_W-1:0] status_q;
  logic                    err_q;
  logic                    timeout_hit;
  logic                    grant_now;

  logic [NUM_REQ-1:0]      arb_grant;
  logic [IDXW-1:0]         arb_idx;
  logic                    arb_any;

  logic [I2C_CHIP_W-1:0]   chip_arr  [NUM_REQ];
  logic [I2C_REG_W-1:0]    reg_arr   [NUM_REQ];
  logic [I2C_DATA_W-1:0]   wdata_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign chip_arr[gi]  = req_chip_addr[gi*I2C_CHIP_W +: I2C_CHIP_W];
    assign reg_arr[gi]   = req_reg_addr[gi*I2C_REG_W +: I2C_REG_W];
    assign wdata_arr[gi] = req_wdata[gi*I2C_DATA_W +: I2C_DATA_W];
  end

  rr_arbiter #(.N(NUM_REQ), .IDXW(IDXW)) u_rr_arbiter (
    .req_i   (req_valid),
    .last_i  (rr_ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .any_o   (arb_any)
  );

  assign grant_now = (state_q == ST_IDLE) && enable && arb_any;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Busy is checked before the limit so a late-but-valid start still wins.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    timeout_hit = 1'b0;
    case (state_q)
      ST_IDLE:  if (grant_now) state_d = ST_ISSUE;
      ST_ISSUE: begin
        state_d = ST_WAIT_START;
        cnt_d   = '0;
      end
      ST_WAIT_START: begin
        if (m_busy) begin
          state_d = ST_WAIT_DONE;
          cnt_d   = '0;
        end else if (cnt_q >= START_LIM) begin
          state_d     = ST_RESP;
          timeout_hit = 1'b1;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      ST_WAIT_DONE: begin
        if (!m_busy) begin
          state_d = ST_RESP;
        end else if (cnt_q >= DONE_LIM) begin
          state_d     = ST_RESP;
          timeout_hit = 1'b1;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = '0;
    rsp_valid  = '0;
    m_write_en = 1'b0;
    m_read_en  = 1'b0;
    case (state_q)
      ST_ISSUE: begin
        req_ready  = grant_oh_q;
        m_write_en = !rw_q;
        m_read_en  = rw_q;
      end
      ST_RESP: rsp_valid = grant_oh_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      rr_ptr_q   <= IDXW'(NUM_REQ - 1);
      grant_oh_q <= '0;
      rw_q       <= 1'b0;
      chip_q     <= '0;
      reg_q      <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      status_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (grant_now) begin
        grant_oh_q <= arb_grant;
        rr_ptr_q   <= arb_idx;
        rw_q       <= req_rw[arb_idx];
        chip_q     <= chip_arr[arb_idx];
        reg_q      <= reg_arr[arb_idx];
        wdata_q    <= wdata_arr[arb_idx];
      end
      if (state_d == ST_RESP && state_q != ST_RESP) begin
        rdata_q  <= rw_q ? m_data_out : '0;
        status_q <= m_status;
        err_q    <= timeout_hit;
      end
    end
  end

  assign m_chip_addr = chip_q;
  assign m_reg_addr  = reg_q;
  assign m_data_in   = wdata_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_status  = status_q;
  assign rsp_err     = err_q;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Directed bench for i2c_req_arbiter with a behavioural i2c master/slave model
// that can complete normally, never start, or never finish.
module tb_i2c_req_arbiter;

  localparam int NR = 4;
  localparam int SW = 8;
  localparam int TO = 100;
  localparam int MODE_NORMAL = 0;
  localparam int MODE_LOW    = 1;
  localparam int MODE_HIGH   = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            enable = 1'b0;
  logic [NR-1:0]   req_valid = '0;
  logic [NR-1:0]   req_rw = '0;
  logic [NR*7-1:0] req_chip_addr = '0;
  logic [NR*8-1:0] req_reg_addr = '0;
  logic [NR*16-1:0] req_wdata = '0;
  logic [NR-1:0]   req_ready, rsp_valid;
  logic [15:0]     rsp_rdata;
  logic [3:0]      rsp_status;
  logic            rsp_err;
  logic [6:0]      m_chip_addr;
  logic [7:0]      m_reg_addr;
  logic [15:0]     m_data_in;
  logic            m_write_en, m_read_en;
  logic [15:0]     m_data_out = '0;
  logic            m_busy = 1'b0;
  logic [3:0]      m_status = '0;

  int n_cmp = 0;
  int n_bad = 0;
  int mode  = MODE_NORMAL;

  i2c_req_arbiter #(.NUM_REQ(NR), .START_WAIT(SW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .req_valid(req_valid), .req_rw(req_rw), .req_chip_addr(req_chip_addr),
    .req_reg_addr(req_reg_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_status(rsp_status), .rsp_err(rsp_err),
    .m_chip_addr(m_chip_addr), .m_reg_addr(m_reg_addr), .m_data_in(m_data_in),
    .m_write_en(m_write_en), .m_read_en(m_read_en),
    .m_data_out(m_data_out), .m_busy(m_busy), .m_status(m_status)
  );

  always #5 clk = ~clk;

  // Master + slave register file model; busy lasts three negedges after the pulse.
  logic [15:0] mem [256];
  int          busy_left = 0;
  logic        p_rd = 1'b0;
  logic [7:0]  p_reg = '0;
  logic [15:0] p_data = '0;

  initial for (int i = 0; i < 256; i++) mem[i] = {8'(i), ~8'(i)};

  always @(negedge clk) begin
    if (reset) begin
      m_busy = 1'b0;
      busy_left = 0;
    end else if (m_write_en || m_read_en) begin
      if (mode != MODE_LOW) begin
        m_busy = 1'b1;
        busy_left = 3;
        p_rd = m_read_en;
        p_reg = m_reg_addr;
        p_data = m_data_in;
      end
    end else if (m_busy && mode == MODE_NORMAL) begin
      if (busy_left > 1) begin
        busy_left = busy_left - 1;
      end else begin
        if (p_rd) begin
          m_data_out = mem[p_reg];
          m_status = 4'h5;
        end else begin
          mem[p_reg] = p_data;
          m_status = 4'hA;
        end
        m_busy = 1'b0;
        busy_left = 0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int idx, input logic rw, input logic [6:0] chip,
                         input logic [7:0] ra, input logic [15:0] wd);
    req_rw[idx] = rw;
    req_chip_addr[idx*7 +: 7] = chip;
    req_reg_addr[idx*8 +: 8] = ra;
    req_wdata[idx*16 +: 16] = wd;
    req_valid[idx] = 1'b1;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (req_ready == '0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("ready_within_bound", 32'(n < 60), 1);
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (rsp_valid == '0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("rsp_within_bound", 32'(n < 400), 1);
  endtask

  typedef struct {
    int          idx;
    logic        rw;
    logic [6:0]  chip;
    logic [7:0]  ra;
    logic [15:0] wd;
    logic [15:0] exp_rdata;
    logic [3:0]  exp_status;
  } vec_t;

  task automatic run_txn(input vec_t v);
    int n;
    logic [NR-1:0] oh;
    oh = '0;
    oh[v.idx] = 1'b1;
    @(negedge clk);
    set_req(v.idx, v.rw, v.chip, v.ra, v.wd);
    wait_ready(n);
    check("req_ready", 32'(req_ready), 32'(oh));
    check("m_write_en", 32'(m_write_en), 32'(!v.rw));
    check("m_read_en", 32'(m_read_en), 32'(v.rw));
    check("m_chip_addr", 32'(m_chip_addr), 32'(v.chip));
    check("m_reg_addr", 32'(m_reg_addr), 32'(v.ra));
    check("m_data_in", 32'(m_data_in), 32'(v.wd));
    req_valid[v.idx] = 1'b0;
    wait_rsp(n);
    check("rsp_latency", 32'(n), 4);
    check("rsp_valid", 32'(rsp_valid), 32'(oh));
    check("rsp_rdata", 32'(rsp_rdata), 32'(v.exp_rdata));
    check("rsp_status", 32'(rsp_status), 32'(v.exp_status));
    check("rsp_err", 32'(rsp_err), 0);
    check("m_reg_stable", 32'(m_reg_addr), 32'(v.ra));
    @(negedge clk);
    @(negedge clk);
    check("rsp_valid_pulse", 32'(rsp_valid), 0);
    check("rdata_held", 32'(rsp_rdata), 32'(v.exp_rdata));
    $display("txn req%0d %s reg=0x%02h wdata=0x%04h -> rdata=0x%04h status=0x%0h err=%0d",
             v.idx, v.rw ? "RD" : "WR", v.ra, v.wd, rsp_rdata, rsp_status, rsp_err);
  endtask

  task automatic collect_grants(input int want, output int got[$]);
    int n;
    got.delete();
    n = 0;
    while (got.size() < want && n < 400) begin
      @(negedge clk);
      n++;
      if (req_ready != '0) begin
        check("ready_onehot", 32'($countones(req_ready)), 1);
        for (int j = 0; j < NR; j++) begin
          if (req_ready[j]) begin
            got.push_back(j);
            req_valid[j] = 1'b0;
            $display("txn contention grant req%0d", j);
          end
        end
      end
    end
    check("grant_count", 32'(got.size()), 32'(want));
  endtask

  initial begin
    vec_t vecs[8];
    int   got[$];
    int   n;
    int   hits;

    vecs[0] = '{0, 1'b0, 7'h0F, 8'h01, 16'hB2B2, 16'h0000, 4'hA};
    vecs[1] = '{2, 1'b1, 7'h0F, 8'h01, 16'h0000, 16'hB2B2, 4'h5};
    vecs[2] = '{1, 1'b0, 7'h22, 8'h7E, 16'h1234, 16'h0000, 4'hA};
    vecs[3] = '{3, 1'b1, 7'h22, 8'h7E, 16'h0000, 16'h1234, 4'h5};
    vecs[4] = '{3, 1'b1, 7'h22, 8'h55, 16'h0000, 16'h55AA, 4'h5};
    vecs[5] = '{1, 1'b0, 7'h0F, 8'hFF, 16'hFFFF, 16'h0000, 4'hA};
    vecs[6] = '{0, 1'b1, 7'h0F, 8'hFF, 16'h0000, 16'hFFFF, 4'h5};
    vecs[7] = '{2, 1'b1, 7'h0F, 8'h12, 16'h0000, 16'hC002, 4'h5};

    // All four requesters valid while still in reset.
    reset = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, 7'h0F, 8'(8'h10 + i), 16'(16'hC000 + i));
    repeat (3) @(negedge clk);
    check("reset_req_ready", 32'(req_ready), 0);
    check("reset_rsp_valid", 32'(rsp_valid), 0);
    check("reset_rsp_data", {rsp_rdata, rsp_status, 11'd0, rsp_err}, 0);
    check("reset_m_addr", {m_chip_addr, m_reg_addr, m_write_en, m_read_en}, 0);
    check("reset_m_data_in", 32'(m_data_in), 0);
    reset = 1'b0;

    collect_grants(4, got);
    for (int k = 0; k < 4; k++) check("grant_order", (k < got.size()) ? 32'(got[k]) : 32'hFFFF_FFFF, 32'(k));
    repeat (8) @(negedge clk);

    // Pointer now at 3: req0 must beat req3.
    set_req(3, 1'b0, 7'h0F, 8'h23, 16'hD003);
    set_req(0, 1'b0, 7'h0F, 8'h20, 16'hD000);
    collect_grants(2, got);
    check("rr_wrap_first", (got.size() > 0) ? 32'(got[0]) : 32'hFFFF_FFFF, 0);
    check("rr_wrap_second", (got.size() > 1) ? 32'(got[1]) : 32'hFFFF_FFFF, 3);
    repeat (8) @(negedge clk);

    for (int i = 0; i < 8; i++) run_txn(vecs[i]);

    // Master never raises busy.
    mode = MODE_LOW;
    @(negedge clk);
    set_req(1, 1'b0, 7'h0F, 8'h30, 16'h1111);
    wait_ready(n);
    check("st_req_ready", 32'(req_ready), 32'b0010);
    req_valid[1] = 1'b0;
    wait_rsp(n);
    check("st_latency", 32'(n), SW + 2);
    check("st_rsp_valid", 32'(rsp_valid), 32'b0010);
    check("st_rsp_err", 32'(rsp_err), 1);
    check("st_rsp_rdata", 32'(rsp_rdata), 0);
    $display("txn req1 start-timeout latency=%0d err=%0d", n, rsp_err);
    mode = MODE_NORMAL;
    repeat (3) @(negedge clk);

    // Master raises busy and never drops it.
    mode = MODE_HIGH;
    @(negedge clk);
    set_req(2, 1'b1, 7'h0F, 8'h01, 16'h0000);
    wait_ready(n);
    check("ct_req_ready", 32'(req_ready), 32'b0100);
    req_valid[2] = 1'b0;
    wait_rsp(n);
    check("ct_latency", 32'(n), TO + 3);
    check("ct_rsp_valid", 32'(rsp_valid), 32'b0100);
    check("ct_rsp_err", 32'(rsp_err), 1);
    $display("txn req2 completion-timeout latency=%0d err=%0d", n, rsp_err);
    mode = MODE_NORMAL;
    repeat (6) @(negedge clk);
    run_txn('{3, 1'b0, 7'h0F, 8'h40, 16'h4242, 16'h0000, 4'hA});

    // enable low blocks grants; dropping it mid-transaction does not.
    enable = 1'b0;
    @(negedge clk);
    set_req(1, 1'b0, 7'h0F, 8'h50, 16'h5050);
    hits = 0;
    repeat (50) begin
      @(negedge clk);
      if (req_ready != '0) hits++;
    end
    check("no_grant_disabled", 32'(hits), 0);
    enable = 1'b1;
    wait_ready(n);
    check("enable_grant_latency", 32'(n), 1);
    check("enable_req_ready", 32'(req_ready), 32'b0010);
    req_valid[1] = 1'b0;
    enable = 1'b0;
    wait_rsp(n);
    check("enable_drop_latency", 32'(n), 4);
    check("enable_drop_rsp", 32'(rsp_valid), 32'b0010);
    $display("txn req1 enable-gated write completed latency=%0d", n);
    enable = 1'b1;
    repeat (3) @(negedge clk);

    // Reset while parked in WAIT_DONE.
    mode = MODE_HIGH;
    @(negedge clk);
    set_req(0, 1'b0, 7'h0F, 8'h60, 16'h6060);
    wait_ready(n);
    req_valid[0] = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_mid_ready_rsp", {req_ready, rsp_valid}, 0);
    check("rst_mid_rsp_data", {rsp_rdata, rsp_status, 11'd0, rsp_err}, 0);
    check("rst_mid_m_addr", {m_chip_addr, m_reg_addr, m_write_en, m_read_en}, 0);
    check("rst_mid_m_data_in", 32'(m_data_in), 0);
    @(negedge clk);
    mode = MODE_NORMAL;
    @(negedge clk);
    reset = 1'b0;
    hits = 0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid != '0 || req_ready != '0) hits++;
    end
    check("rst_mid_no_rsp", 32'(hits), 0);
    $display("txn req0 write aborted by reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no end, required end");
    $fatal(1);
  end

endmodule
